// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared helpers for the synchronous FIFO.
//   wrap_inc - advance a ring index, returning to 0 after the last slot.
//              Uses an explicit compare so non-power-of-two depths wrap correctly.
package sync_fifo_pkg;

  function automatic logic [31:0] wrap_inc(input logic [31:0] idx,
                                           input logic [31:0] depth);
    return (idx == depth - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered read port and occupancy status.
// Ports:
//   i_clock   - clock, all state changes on the rising edge
//   i_reset   - asynchronous active-high reset
//   i_write   - push request
//   i_wdata   - push data
//   i_read    - pop request
//   o_rdata   - registered pop data, changes only on an accepted pop
//   o_empty   - occupancy is zero
//   o_full    - occupancy equals DEPTH
//   o_queued  - current occupancy, 0..DEPTH
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_write,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_read,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_queued
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0] rdata_q,  rdata_d;

  logic empty, full, push_ok, pop_ok;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    // Acceptance uses the flags from before the edge, so a full FIFO with
    // both requests only pops and an empty one with both only pushes.
    push_ok = i_write && !full;
    pop_ok  = i_read && !empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;

    if (push_ok) begin
      wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), 32'(DEPTH)));
    end
    if (pop_ok) begin
      rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), 32'(DEPTH)));
      rdata_d  = mem_q[rd_ptr_q];
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately not reset so it can map onto RAM.
  always_ff @(posedge i_clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_rdata  = rdata_q;
  assign o_empty  = empty;
  assign o_full   = full;
  assign o_queued = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;

  logic             i_clock = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_write = 1'b0;
  logic [WIDTH-1:0] i_wdata = '0;
  logic             i_read  = 1'b0;
  logic [WIDTH-1:0] o_rdata;
  logic             o_empty;
  logic             o_full;
  logic [4:0]       o_queued;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_write (i_write),
    .i_wdata (i_wdata),
    .i_read  (i_read),
    .o_rdata (o_rdata),
    .o_empty (o_empty),
    .o_full  (o_full),
    .o_queued(o_queued)
  );

  always #5 i_clock = ~i_clock;

  // Reference model: a plain queue plus the last popped value.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] m_rdata = '0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rdata"},  o_rdata,         m_rdata);
    chk({tag, ".queued"}, 32'(o_queued),   32'(model_q.size()));
    chk({tag, ".empty"},  32'(o_empty),    32'(model_q.size() == 0));
    chk({tag, ".full"},   32'(o_full),     32'(model_q.size() == DEPTH));
  endtask

  // One clock: drive requests, advance the model by the queue rules, check after the edge.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input string tag);
    bit push_ok, pop_ok;
    i_write = w;
    i_wdata = d;
    i_read  = r;
    push_ok = w && (model_q.size() < DEPTH);
    pop_ok  = r && (model_q.size() > 0);
    @(posedge i_clock);
    if (pop_ok)  m_rdata = model_q.pop_front();
    if (push_ok) model_q.push_back(d);
    #1;
    i_write = 1'b0;
    i_read  = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] seq;
    #1;
    chk_all("reset_hold");
    #11;
    i_reset = 1'b0;
    step(0, '0, 0, "idle");

    // Three pushes, then spaced single-cycle pops.
    step(1, 32'hA1, 0, "push_a1");
    step(1, 32'hB2, 0, "push_b2");
    step(1, 32'hC3, 0, "push_c3");
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, "spaced_pop");
      step(0, '0, 0, "spaced_gap1");
      step(0, '0, 0, "spaced_gap2");
    end

    // Fill past capacity; the 17th push must be dropped.
    for (int i = 0; i <= DEPTH; i++) step(1, 32'(i), 0, "fill");
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, "drain");

    // Pop while empty holds the last value.
    step(0, '0, 1, "pop_empty");
    step(0, '0, 1, "pop_empty2");

    // Simultaneous push/pop at occupancy 5.
    seq = 32'h100;
    for (int i = 0; i < 5; i++) begin step(1, seq, 0, "pre5"); seq++; end
    for (int i = 0; i < 10; i++) begin step(1, seq, 1, "both_at5"); seq++; end
    // Fill to DEPTH, then both requests: only the pop is taken.
    while (model_q.size() < DEPTH) begin step(1, seq, 0, "to_full"); seq++; end
    step(1, 32'hDEAD, 1, "both_at_full");
    while (model_q.size() > 0) step(0, '0, 1, "drain2");
    // Empty with both requests: only the push is taken.
    step(1, 32'h77, 1, "both_at_empty");
    step(0, '0, 1, "pop77");

    // Asynchronous reset mid-stream at occupancy 7.
    for (int i = 0; i < 7; i++) step(1, 32'h200 + 32'(i), 0, "pre_rst");
    step(0, '0, 1, "pop_pre_rst");
    step(1, 32'h300, 0, "refill7");
    #2;
    i_reset = 1'b1;
    model_q.delete();
    m_rdata = '0;
    #1;
    chk_all("async_reset");
    #2;
    i_reset = 1'b0;
    step(1, 32'h5A, 0, "push_5a");
    step(0, '0, 1, "pop_5a");
    chk("pop_5a_value", o_rdata, 32'h5A);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 45), "random");
    end
    while (model_q.size() > 0) step(0, '0, 1, "final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
